fei4_cmd_decoder: RTL and testbench

- Serial decoder for the FE-I4 command stream (CMD_DATA), i.e. the chip-side counterpart of the FPGA command sequencer.
- Samples one bit per CMD_CLK and recognises trigger, fast and slow commands.
- Emits single-cycle strobes with the decoded fields.
- Used in the FPGA as a loopback monitor of the transmitted command stream, and in simulation as a lightweight FE emulator front end.

---
 rtl/fei4_cmd_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_fei4_cmd_decoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fei4_cmd_decoder.sv
// FE-I4 serial command decoder: samples CMD_DATA MSB-first on every rising
// CMD_CLK and turns trigger, fast and slow commands into registered strobes.
// Handshake: every strobe (LV1 .. CMD_ERR, FE_BIT_VLD, FE_DONE) is a one-cycle
// valid pulse with no ready/backpressure; REG_ADDR, REG_DATA and RUN_EN are
// levels that change only in the cycle their owning strobe is high.
module fei4_cmd_decoder #(
  parameter int FE_BITS = 672
) (
  input  logic        CMD_CLK,
  input  logic        RST,
  input  logic        CMD_DATA,
  input  logic [2:0]  CHIP_ID,
  output logic        LV1,
  output logic        BCR,
  output logic        ECR,
  output logic        CAL,
  output logic        RD_REG,
  output logic        WR_REG,
  output logic        GRST,
  output logic        GPULSE,
  output logic        RUNMODE,
  output logic [5:0]  REG_ADDR,
  output logic [15:0] REG_DATA,
  output logic        RUN_EN,
  output logic        FE_BIT,
  output logic        FE_BIT_VLD,
  output logic        FE_DONE,
  output logic        CMD_ERR,
  output logic        BUSY,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_F2, S_F3, S_ID, S_ADDR, S_DATA16, S_FEDATA
  } state_t;

  localparam logic [3:0] C_RDREG   = 4'b0001;
  localparam logic [3:0] C_WRREG   = 4'b0010;
  localparam logic [3:0] C_WRFE    = 4'b0100;
  localparam logic [3:0] C_GRST    = 4'b1000;
  localparam logic [3:0] C_GPULSE  = 4'b1001;
  localparam logic [3:0] C_RUNMODE = 4'b1010;

  // bit positions inside the strobe vector
  localparam int I_LV1 = 11, I_BCR = 10, I_ECR = 9, I_CAL = 8, I_RD = 7, I_WR = 6;
  localparam int I_GRST = 5, I_GP = 4, I_RUN = 3, I_VLD = 2, I_DONE = 1, I_ERR = 0;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_cnt, w_cnt_nxt, w_len_m1;
  logic [14:0] r_sh;
  logic [15:0] w_bits;
  logic        w_last, w_id_match;
  logic [3:0]  r_code, w_code_nxt;
  logic        r_match, w_match_nxt;
  logic [5:0]  r_waddr, w_waddr_nxt;
  logic [5:0]  r_reg_addr, w_reg_addr_nxt;
  logic [15:0] r_reg_data, w_reg_data_nxt;
  logic        r_run_en, w_run_en_nxt;
  logic        r_fe_bit, w_fe_bit_nxt;
  logic [11:0] r_strb, w_strb_nxt;

  // The shifter always holds the most recent samples, so each field is simply
  // the low bits of the shifted word when its last bit arrives.
  assign w_bits     = {r_sh, CMD_DATA};
  assign w_id_match = w_bits[3] | (w_bits[2:0] == CHIP_ID);
  assign w_last     = (r_cnt == w_len_m1);

  // Last counter value of the field collected in the current state
  always_comb begin
    w_len_m1 = 10'd0;
    case (r_state)
      S_HDR:             w_len_m1 = 10'd4;  // bit 0 was counted in IDLE
      S_F2, S_F3, S_ID:  w_len_m1 = 10'd3;
      S_ADDR:            w_len_m1 = 10'd5;
      S_DATA16:          w_len_m1 = 10'd15;
      S_FEDATA:          w_len_m1 = 10'(FE_BITS - 1);
      default:           w_len_m1 = 10'd0;
    endcase
  end

  // State register
  always_ff @(posedge CMD_CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and next values of all registered outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 10'd1;
    w_code_nxt     = r_code;
    w_match_nxt    = r_match;
    w_waddr_nxt    = r_waddr;
    w_reg_addr_nxt = r_reg_addr;
    w_reg_data_nxt = r_reg_data;
    w_run_en_nxt   = r_run_en;
    w_fe_bit_nxt   = 1'b0;
    w_strb_nxt     = '0;
    if (r_state != S_IDLE && w_last) w_cnt_nxt = 10'd0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 10'd0;
        if (CMD_DATA) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 10'd1;
        end
      end
      S_HDR: if (w_last) begin
        w_state_nxt = S_IDLE;
        if (w_bits[4:0] == 5'b11101)      w_strb_nxt[I_LV1] = 1'b1;
        else if (w_bits[4:0] == 5'b10110) w_state_nxt = S_F2;
        else                              w_strb_nxt[I_ERR] = 1'b1;
      end
      S_F2: if (w_last) begin
        w_state_nxt = S_IDLE;
        case (w_bits[3:0])
          4'b0001: w_strb_nxt[I_BCR] = 1'b1;
          4'b0010: w_strb_nxt[I_ECR] = 1'b1;
          4'b0100: w_strb_nxt[I_CAL] = 1'b1;
          4'b1000: w_state_nxt = S_F3;
          default: w_strb_nxt[I_ERR] = 1'b1;
        endcase
      end
      S_F3: if (w_last) begin
        w_code_nxt = w_bits[3:0];
        case (w_bits[3:0])
          C_RDREG, C_WRREG, C_WRFE, C_GRST, C_GPULSE, C_RUNMODE: w_state_nxt = S_ID;
          default: begin
            w_state_nxt       = S_IDLE;
            w_strb_nxt[I_ERR] = 1'b1;
          end
        endcase
      end
      S_ID: if (w_last) begin
        // A foreign chip still consumes the payload, so the match is kept
        w_match_nxt = w_id_match;
        if (r_code == C_GRST) begin
          w_state_nxt        = S_IDLE;
          w_strb_nxt[I_GRST] = w_id_match;
        end else begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: if (w_last) begin
        w_state_nxt = S_IDLE;
        case (r_code)
          C_RDREG: if (r_match) begin
            w_reg_addr_nxt   = w_bits[5:0];
            w_strb_nxt[I_RD] = 1'b1;
          end
          C_GPULSE: if (r_match) begin
            w_reg_data_nxt   = {10'b0, w_bits[5:0]};
            w_strb_nxt[I_GP] = 1'b1;
          end
          C_RUNMODE: if (r_match) begin
            if (w_bits[5:0] == 6'b111000) begin
              w_run_en_nxt      = 1'b1;
              w_strb_nxt[I_RUN] = 1'b1;
            end else if (w_bits[5:0] == 6'b000111) begin
              w_run_en_nxt      = 1'b0;
              w_strb_nxt[I_RUN] = 1'b1;
            end else begin
              w_strb_nxt[I_ERR] = 1'b1;
            end
          end
          C_WRREG: begin
            w_waddr_nxt = w_bits[5:0];
            w_state_nxt = S_DATA16;
          end
          C_WRFE:  w_state_nxt = S_FEDATA;
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_DATA16: if (w_last) begin
        w_state_nxt = S_IDLE;
        if (r_match) begin
          w_reg_addr_nxt   = r_waddr;
          w_reg_data_nxt   = w_bits;
          w_strb_nxt[I_WR] = 1'b1;
        end
      end
      S_FEDATA: begin
        w_strb_nxt[I_VLD] = r_match;
        w_fe_bit_nxt      = r_match & CMD_DATA;
        if (w_last) begin
          w_state_nxt        = S_IDLE;
          w_strb_nxt[I_DONE] = r_match;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CMD_CLK or posedge RST) begin
    if (RST) begin
      r_cnt      <= '0;
      r_sh       <= '0;
      r_code     <= '0;
      r_match    <= 1'b0;
      r_waddr    <= '0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_run_en   <= 1'b0;
      r_fe_bit   <= 1'b0;
      r_strb     <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_sh       <= w_bits[14:0];
      r_code     <= w_code_nxt;
      r_match    <= w_match_nxt;
      r_waddr    <= w_waddr_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_reg_data <= w_reg_data_nxt;
      r_run_en   <= w_run_en_nxt;
      r_fe_bit   <= w_fe_bit_nxt;
      r_strb     <= w_strb_nxt;
    end
  end

  assign LV1        = r_strb[I_LV1];
  assign BCR        = r_strb[I_BCR];
  assign ECR        = r_strb[I_ECR];
  assign CAL        = r_strb[I_CAL];
  assign RD_REG     = r_strb[I_RD];
  assign WR_REG     = r_strb[I_WR];
  assign GRST       = r_strb[I_GRST];
  assign GPULSE     = r_strb[I_GP];
  assign RUNMODE    = r_strb[I_RUN];
  assign FE_BIT_VLD = r_strb[I_VLD];
  assign FE_DONE    = r_strb[I_DONE];
  assign CMD_ERR    = r_strb[I_ERR];
  assign FE_BIT     = r_fe_bit;
  assign REG_ADDR   = r_reg_addr;
  assign REG_DATA   = r_reg_data;
  assign RUN_EN     = r_run_en;
  assign BUSY       = (r_state != S_IDLE);
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_fei4_cmd_decoder.sv
// Bench for fei4_cmd_decoder: commands are assembled at the bit level from
// their field layout, the expected strobes are pushed into exp_q with the
// cycle they must appear in, and a monitor pops and compares each DUT output.
module tb_fei4_cmd_decoder;
  localparam int FE_BITS = 672;
  localparam int W = 56;  // {cycle[19:0], strobes[11:0], addr, data, run_en, fe_bit}

  localparam int B_LV1 = 11, B_BCR = 10, B_ECR = 9, B_CAL = 8, B_RD = 7, B_WR = 6;
  localparam int B_GRST = 5, B_GP = 4, B_RUN = 3, B_VLD = 2, B_DONE = 1, B_ERR = 0;

  localparam int K_LV1 = 0, K_BCR = 1, K_ECR = 2, K_CAL = 3, K_RD = 4, K_WR = 5, K_GRST = 6;
  localparam int K_GP = 7, K_RUN = 8, K_FE = 9, K_BADH = 10, K_BADF = 11, K_BADS = 12;

  logic        CMD_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_DATA = 1'b0;
  logic [2:0]  CHIP_ID = 3'd0;
  logic        LV1, BCR, ECR, CAL, RD_REG, WR_REG, GRST, GPULSE, RUNMODE;
  logic [5:0]  REG_ADDR;
  logic [15:0] REG_DATA;
  logic        RUN_EN, FE_BIT, FE_BIT_VLD, FE_DONE, CMD_ERR, BUSY;
  logic [2:0]  dbg_state;
  logic [36:0] all_out;
  logic [11:0] act_mask;

  logic [W-1:0] exp_q[$];
  bit           bq[$];
  int           ev_idx[$];
  logic [35:0]  ev_pay[$];

  logic [5:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_run  = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int fe_vld_cnt = 0;

  fei4_cmd_decoder #(.FE_BITS(FE_BITS)) dut (
    .CMD_CLK(CMD_CLK), .RST(RST), .CMD_DATA(CMD_DATA), .CHIP_ID(CHIP_ID),
    .LV1(LV1), .BCR(BCR), .ECR(ECR), .CAL(CAL), .RD_REG(RD_REG), .WR_REG(WR_REG),
    .GRST(GRST), .GPULSE(GPULSE), .RUNMODE(RUNMODE), .REG_ADDR(REG_ADDR),
    .REG_DATA(REG_DATA), .RUN_EN(RUN_EN), .FE_BIT(FE_BIT), .FE_BIT_VLD(FE_BIT_VLD),
    .FE_DONE(FE_DONE), .CMD_ERR(CMD_ERR), .BUSY(BUSY), .DBG_STATE(dbg_state)
  );

  assign act_mask = {LV1, BCR, ECR, CAL, RD_REG, WR_REG, GRST, GPULSE, RUNMODE,
                     FE_BIT_VLD, FE_DONE, CMD_ERR};
  assign all_out  = {act_mask, REG_ADDR, REG_DATA, RUN_EN, FE_BIT, BUSY};

  // ---------------- clock / cycle counter ----------------
  initial forever #5 CMD_CLK = ~CMD_CLK;
  initial forever begin
    @(posedge CMD_CLK);
    cyc++;
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    logic [W-1:0] act, exp;
    @(posedge CMD_CLK);
    #1;
    if (BUSY) busy_cnt++;
    if (FE_BIT_VLD) fe_vld_cnt++;
    if (act_mask != 12'd0) begin
      act = {cyc[19:0], act_mask, REG_ADDR, REG_DATA, RUN_EN, FE_BIT};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d act=%h (nothing expected)", cyc, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL output_event cyc=%0d act=%h exp=%h", cyc, act, exp);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0][W-1:36] < cyc[19:0]) begin
      checks++;
      errors++;
      $display("FAIL missing_output cyc=%0d act=none exp=%h", cyc, exp_q[0]);
      void'(exp_q.pop_front());
    end
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [11:0] one(input int b);
    return 12'b1 << b;
  endfunction

  task automatic add_ev(input int idx, input logic [11:0] mask, input logic fb);
    ev_idx.push_back(idx);
    ev_pay.push_back({mask, m_addr, m_data, m_run, fb});
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  function automatic bit slow_ok(input logic [3:0] c);
    return c == 4'b0001 || c == 4'b0010 || c == 4'b0100 ||
           c == 4'b1000 || c == 4'b1001 || c == 4'b1010;
  endfunction

  // Assemble a command and the outputs it must produce (bit index of the
  // sample that completes each output); the model registers are updated here.
  task automatic build(input int kind, input logic [3:0] id, input logic [5:0] fld,
                       input logic [15:0] data, input bit alt);
    logic [4:0] h;
    logic [3:0] c;
    logic [3:0] code;
    bit match, b;
    bq.delete(); ev_idx.delete(); ev_pay.delete();
    match = id[3] || (id[2:0] == CHIP_ID);
    case (kind)
      K_LV1: begin push_bits(32'b11101, 5); add_ev(4, one(B_LV1), 1'b0); end
      K_BCR: begin push_bits(32'b10110_0001, 9); add_ev(8, one(B_BCR), 1'b0); end
      K_ECR: begin push_bits(32'b10110_0010, 9); add_ev(8, one(B_ECR), 1'b0); end
      K_CAL: begin push_bits(32'b10110_0100, 9); add_ev(8, one(B_CAL), 1'b0); end
      K_BADH: begin
        if (fld != 6'd0) h = fld[4:0];
        else do h = 5'(16 + $urandom_range(0, 15)); while (h == 5'b11101 || h == 5'b10110);
        push_bits(32'(h), 5); add_ev(4, one(B_ERR), 1'b0);
      end
      K_BADF: begin
        do c = 4'($urandom_range(0, 15)); while (c == 4'd1 || c == 4'd2 || c == 4'd4 || c == 4'd8);
        push_bits({23'd0, 5'b10110, c}, 9); add_ev(8, one(B_ERR), 1'b0);
      end
      K_BADS: begin
        do c = 4'($urandom_range(0, 15)); while (slow_ok(c));
        push_bits({19'd0, 9'b10110_1000, c}, 13); add_ev(12, one(B_ERR), 1'b0);
      end
      default: begin
        case (kind)
          K_RD:    code = 4'b0001;
          K_WR:    code = 4'b0010;
          K_FE:    code = 4'b0100;
          K_GRST:  code = 4'b1000;
          K_GP:    code = 4'b1001;
          default: code = 4'b1010;
        endcase
        push_bits({15'd0, 9'b10110_1000, code, id}, 17);
        if (kind == K_GRST) begin
          if (match) add_ev(16, one(B_GRST), 1'b0);
        end else begin
          push_bits(32'(fld), 6);
          if (kind == K_RD && match) begin
            m_addr = fld; add_ev(22, one(B_RD), 1'b0);
          end else if (kind == K_GP && match) begin
            m_data = {10'd0, fld}; add_ev(22, one(B_GP), 1'b0);
          end else if (kind == K_RUN && match) begin
            if (fld == 6'b111000)      begin m_run = 1'b1; add_ev(22, one(B_RUN), 1'b0); end
            else if (fld == 6'b000111) begin m_run = 1'b0; add_ev(22, one(B_RUN), 1'b0); end
            else add_ev(22, one(B_ERR), 1'b0);
          end else if (kind == K_WR) begin
            push_bits(32'(data), 16);
            if (match) begin m_addr = fld; m_data = data; add_ev(38, one(B_WR), 1'b0); end
          end else if (kind == K_FE) begin
            for (int i = 0; i < FE_BITS; i++) begin
              b = alt ? (i % 2 == 0) : bit'($urandom_range(0, 1));
              bq.push_back(b);
              if (match)
                add_ev(23 + i, one(B_VLD) | ((i == FE_BITS - 1) ? one(B_DONE) : 12'd0), b);
            end
          end
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input int nbits);
    int e;
    e = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge CMD_CLK);
      CMD_DATA = bq[i];
      while (e < ev_idx.size() && ev_idx[e] == i) begin
        exp_q.push_back({20'(cyc + 1), ev_pay[e]});
        e++;
      end
    end
  endtask

  task automatic send(input int kind, input logic [3:0] id, input logic [5:0] fld,
                      input logic [15:0] data, input bit alt);
    build(kind, id, fld, data, alt);
    drive_cmd(bq.size());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CMD_CLK);
      CMD_DATA = 1'b0;
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kind, gap;
    logic [5:0] fld;
    // reset
    repeat (3) @(posedge CMD_CLK);
    #1 check_val("reset_outputs", 32'(all_out), 32'd0);
    check_val("reset_outputs_hi", 32'(all_out[36:32]), 32'd0);
    @(negedge CMD_CLK) RST = 1'b0;

    // 0000_11101_000: single LV1, BUSY for four cycles
    idle(4);
    busy_cnt = 0;
    send(K_LV1, 4'd0, 6'd0, 16'd0, 1'b0);
    idle(3);
    check_val("lv1_busy_cycles", 32'(busy_cnt), 32'd4);

    // ECR immediately followed by LV1
    send(K_ECR, 4'd0, 6'd0, 16'd0, 1'b0);
    send(K_LV1, 4'd0, 6'd0, 16'd0, 1'b0);
    idle(3);

    // WrReg for this chip, then for another chip
    CHIP_ID = 3'b000;
    send(K_WR, 4'b0000, 6'd27, 16'h8000, 1'b0);
    idle(2);
    check_val("wrreg_addr", 32'(REG_ADDR), 32'd27);
    check_val("wrreg_data", 32'(REG_DATA), 32'h8000);
    send(K_WR, 4'b0011, 6'd5, 16'h1234, 1'b0);
    idle(2);
    check_val("wrreg_other_addr", 32'(REG_ADDR), 32'd27);
    check_val("wrreg_other_data", 32'(REG_DATA), 32'h8000);

    // RunMode on, GlobalPulse width 10, RunMode off
    send(K_RUN, 4'b0000, 6'b111000, 16'd0, 1'b0);
    idle(2);
    check_val("run_en_on", 32'(RUN_EN), 32'd1);
    send(K_GP, 4'b0000, 6'd10, 16'd0, 1'b0);
    idle(2);
    check_val("gpulse_width", 32'(REG_DATA), 32'd10);
    send(K_RUN, 4'b0000, 6'b000111, 16'd0, 1'b0);
    idle(2);
    check_val("run_en_off", 32'(RUN_EN), 32'd0);

    // WrFrontEnd with an alternating pattern
    fe_vld_cnt = 0;
    send(K_FE, 4'b0000, 6'd33, 16'd0, 1'b1);
    idle(3);
    check_val("fe_valid_count", 32'(fe_vld_cnt), 32'(FE_BITS));

    // Illegal header
    send(K_BADH, 4'd0, 6'b011001, 16'd0, 1'b0);
    idle(1);
    check_val("badhdr_idle", 32'(BUSY), 32'd0);

    // Reset in the middle of a WrReg data field, then a normal LV1
    build(K_WR, 4'b0000, 6'd12, 16'hBEEF, 1'b0);
    drive_cmd(30);
    @(negedge CMD_CLK);
    RST = 1'b1;
    CMD_DATA = 1'b0;
    m_addr = '0; m_data = '0; m_run = 1'b0;
    @(posedge CMD_CLK);
    #1 check_val("midcmd_reset_outputs", 32'(all_out), 32'd0);
    check_val("midcmd_reset_outputs_hi", 32'(all_out[36:32]), 32'd0);
    @(negedge CMD_CLK) RST = 1'b0;
    idle(2);
    send(K_LV1, 4'd0, 6'd0, 16'd0, 1'b0);
    idle(3);

    // Randomized command stream, including back-to-back commands
    for (int n = 0; n < 80; n++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle(gap);
        if ($urandom_range(0, 5) == 0) CHIP_ID = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) < 3) kind = K_FE;
      else begin
        kind = $urandom_range(0, 12);
        if (kind == K_FE) kind = K_LV1;
      end
      fld = 6'($urandom_range(0, 63));
      if (kind == K_RUN) begin
        case ($urandom_range(0, 2))
          0: fld = 6'b111000;
          1: fld = 6'b000111;
          default: ;
        endcase
      end
      if (kind == K_BADH) fld = 6'd0;
      send(kind, 4'($urandom_range(0, 15)), fld, 16'($urandom_range(0, 65535)), 1'b0);
    end
    idle(5);
    check_val("final_regaddr", 32'(REG_ADDR), 32'(m_addr));
    check_val("final_regdata", 32'(REG_DATA), 32'(m_data));
    check_val("final_run_en", 32'(RUN_EN), 32'(m_run));
    check_val("expected_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
